if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch stage and the decode stage of the RV32 core.
- Captures the fetch PC and the instruction word returned by the instruction ROM, aligns them for a synchronous (1-cycle) ROM, and computes PC+4.
- Supports decode-side stall (hold) and flush (bubble insertion).
- Presents a valid bit and a canonical NOP to decode, and keeps saturating stall/flush event counters for debug.

Parameters:
- SYNC_ROM, 1, 1: ROM data arrives one cycle after the address; 0: ROM is combinational, same-cycle.
- NOP_INST, 32'h00000013, instruction injected on reset and flush (addi x0,x0,0).
- CNT_W, 16, width of stall and flush event counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_IF  in  32  PC currently driven by fetch; its [9:2] addresses the ROM.
- inst_rom  in  32  ROM data output.
- stall_ID  in  1  hold decode-stage contents; fetch PC is also held upstream by the hazard unit.
- flush_ID  in  1  discard the instruction entering decode (taken branch/jump).
- pc_ID  out  32  PC of the instruction in decode.
- pc4_ID  out  32  pc_ID + 4.
- inst_ID  out  32  instruction in decode.
- valid_ID  out  1  inst_ID is a real fetched instruction, not a bubble.
- stall_cnt  out  CNT_W  cycles with stall_ID=1 and flush_ID=0; saturates at all-ones.
- flush_cnt  out  CNT_W  cycles with flush_ID=1; saturates.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - pc_ID=0, pc4_ID=4, inst_ID=NOP_INST, valid_ID=0, counters=0.
  - Internal align/hold state cleared.
- Alignment with SYNC_ROM=1:
  - Internal pc_q registers pc_IF each non-stalled cycle.
  - The captured pair is {pc_q, inst_rom}.
  - A prime flag is cleared by reset and sets after the first post-reset edge. Until it sets, the incoming pair is invalid, so the first cycle after reset loads a bubble.
- Alignment with SYNC_ROM=0: the pair is {pc_IF, inst_rom} and is always valid.
- Priority per rising edge: flush_ID > stall_ID > normal advance.
  - Flush: inst_ID=NOP_INST, valid_ID=0, pc_ID/pc4_ID unchanged. This also applies when stall is simultaneously high. The prime flag is cleared, because the fetch in flight at a flush belongs to the wrong path.
  - Stall: all outputs hold. On the first stall cycle only, inst_rom is captured into a 32-bit hold buffer and hold_vld is set. This covers a synchronous ROM whose output would otherwise advance.
  - Advance: load the pair into the outputs, with valid_ID = pair valid. If hold_vld=1, take the instruction from the hold buffer instead of inst_rom, then clear hold_vld.
- pc4_ID is registered, not computed combinationally. It is computed as 32-bit add with wrap: 0xFFFFFFFC -> 0x00000000.
- Back-to-back stalls of any length hold outputs indefinitely. The hold buffer is written only once per stall episode.
- A stall released together with a flush takes the flush path, and hold_vld clears.
- Counters: increment by 1 per qualifying cycle and stick at 2^CNT_W-1. They are reset only by rst_n.
- Reset asserted mid-stall or mid-flush overrides everything immediately. After release, the behaviour matches a fresh power-up.
- Latency: an instruction presented at the pair input appears on inst_ID one clock later.

Decomposition:
- Shared pipeline package holds:
  - NOP encoding constant.
  - Instruction/PC width constants (XLEN=32).
  - Type for the pipeline payload struct {pc, pc4, inst, valid}, reused by ID/EX and EX/MEM registers.
- One sub-module, sat_counter (parameter W; inputs inc, outputs cnt), instantiated twice.

Test Plan:
- Reset then free-run, SYNC_ROM=1, PC 0,4,8 with ROM words A,B,C.
  - Required: cycle 1 valid_ID=0, inst_ID=0x00000013.
  - Then {pc_ID,inst_ID,valid_ID} = {0,A,1},{4,B,1},{8,C,1}, with pc4_ID=4,8,12.
- Stall 3 cycles while pc_ID=4 (inst B); the ROM output changes to garbage during the stall.
  - Required: outputs hold {4,B}; after release the next pair is {8,C} (from the hold buffer).
  - Required: stall_cnt=3.
- Flush while pc_ID=8.
  - Required: next cycle inst_ID=0x00000013, valid_ID=0, pc_ID=8, flush_cnt=1.
  - Required: the following cycle also shows valid_ID=0 (re-prime); the first valid instruction comes from the new target PC 0x40.
- stall_ID=1 and flush_ID=1 in the same cycle.
  - Required: bubble inserted, stall_cnt unchanged, flush_cnt+1.
- pc_IF=0xFFFFFFFC.
  - Required: pc4_ID=0x00000000.
- Counter saturation and async reset, CNT_W=4: hold stall for 20 cycles.
  - Required: stall_cnt=15, no wrap.
  - Required: rst_n low mid-cycle immediately gives valid_ID=0, counters=0.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared pipeline definitions: widths, canonical NOP and the stage payload
// carried by the IF/ID, ID/EX and EX/MEM registers.
package if_id_reg_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } pipe_payload_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (inc && (r_cnt != {W{1'b1}})) r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: aligns fetch PC with (optionally synchronous) ROM
// data, handles decode stall/flush and counts stall/flush events.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter bit              SYNC_ROM = 1'b1,
  parameter logic [XLEN-1:0] NOP_INST = RV_NOP,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_IF,
  input  logic [XLEN-1:0]  inst_rom,
  input  logic             stall_ID,
  input  logic             flush_ID,
  output logic [XLEN-1:0]  pc_ID,
  output logic [XLEN-1:0]  pc4_ID,
  output logic [XLEN-1:0]  inst_ID,
  output logic             valid_ID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam pipe_payload_t RST_PAYLOAD = '{pc: '0, pc4: 32'd4, inst: NOP_INST, valid: 1'b0};

  pipe_payload_t   r_id;
  pipe_payload_t   w_next;
  logic [XLEN-1:0] r_hold_inst;
  logic            r_hold_vld;
  logic [XLEN-1:0] w_pair_pc;
  logic [XLEN-1:0] w_pair_inst;
  logic            w_pair_vld;

  generate
    if (SYNC_ROM) begin : g_sync
      // ROM data lags its address by a cycle, so pair it with last cycle's PC.
      // The prime flag marks whether that address belongs to the current path.
      logic [XLEN-1:0] r_pc_q;
      logic            r_prime;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pc_q  <= '0;
          r_prime <= 1'b0;
        end else begin
          if (!stall_ID) r_pc_q <= pc_IF;
          r_prime <= !flush_ID;
        end
      end

      assign w_pair_pc  = r_pc_q;
      assign w_pair_vld = r_prime;
    end else begin : g_comb
      assign w_pair_pc  = pc_IF;
      assign w_pair_vld = 1'b1;
    end
  endgenerate

  assign w_pair_inst = r_hold_vld ? r_hold_inst : inst_rom;

  always_comb begin
    w_next = r_id;
    if (flush_ID) begin
      w_next.inst  = NOP_INST;
      w_next.valid = 1'b0;
    end else if (!stall_ID) begin
      w_next.pc    = w_pair_pc;
      w_next.pc4   = pc_plus4(w_pair_pc);
      w_next.inst  = w_pair_vld ? w_pair_inst : NOP_INST;
      w_next.valid = w_pair_vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_id <= RST_PAYLOAD;
    else        r_id <= w_next;
  end

  // Capture the ROM word once per stall episode; a sync ROM moves on afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_inst <= '0;
    end else if (flush_ID || !stall_ID) begin
      r_hold_vld  <= 1'b0;
    end else if (!r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_hold_inst <= inst_rom;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_ID && !flush_ID),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_ID),
    .cnt   (flush_cnt)
  );

  assign pc_ID    = r_id.pc;
  assign pc4_ID   = r_id.pc4;
  assign inst_ID  = r_id.inst;
  assign valid_ID = r_id.valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed vector table on a sync-ROM instance, random
// traffic against a reference model on sync and combinational-ROM instances.
module tb_if_id_reg;
  import if_id_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_IF = '0;
  logic [31:0] rom_q = '0;
  logic [31:0] rnd_inst = '0;
  logic [31:0] inst_rom;
  logic        stall_ID = 1'b0, flush_ID = 1'b0;
  logic        garb = 1'b0, use_rnd = 1'b0;

  logic [31:0] s_pc, s_pc4, s_inst, c_pc, c_pc4, c_inst;
  logic        s_vld, c_vld;
  logic [15:0] s_scnt, s_fcnt;
  logic [3:0]  c_scnt, c_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {8'hC0 ^ a[9:2], a[9:2], 16'h0B37};
  endfunction

  always @(posedge clk) rom_q <= rom_word(pc_IF);
  assign inst_rom = use_rnd ? rnd_inst : (garb ? 32'hDEAD_BEEF : rom_q);

  if_id_reg #(.SYNC_ROM(1'b1), .NOP_INST(RV_NOP), .CNT_W(16)) u_s (
    .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .inst_rom(inst_rom),
    .stall_ID(stall_ID), .flush_ID(flush_ID),
    .pc_ID(s_pc), .pc4_ID(s_pc4), .inst_ID(s_inst), .valid_ID(s_vld),
    .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  if_id_reg #(.SYNC_ROM(1'b0), .NOP_INST(RV_NOP), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .inst_rom(inst_rom),
    .stall_ID(stall_ID), .flush_ID(flush_ID),
    .pc_ID(c_pc), .pc4_ID(c_pc4), .inst_ID(c_inst), .valid_ID(c_vld),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        st, fl, gb;
    logic [31:0] epc, epc4, einst;
    logic        evld;
    logic [15:0] esc, efc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] pc, input logic st, fl, gb,
                              input logic [31:0] epc, epc4, einst, input logic evld,
                              input logic [15:0] esc, efc);
    vec_t v;
    v.pc = pc; v.st = st; v.fl = fl; v.gb = gb;
    v.epc = epc; v.epc4 = epc4; v.einst = einst; v.evld = evld;
    v.esc = esc; v.efc = efc;
    return v;
  endfunction

  // Reference model: what decode should see, derived from fetch history.
  typedef struct {
    logic [31:0] pc, pc4, inst;
    logic        vld;
    bit          held;
    logic [31:0] hinst;
    int          sc, fc;
    logic [31:0] issued;
    bit          primed;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.pc = '0; m.pc4 = 32'd4; m.inst = RV_NOP; m.vld = 1'b0;
    m.held = 1'b0; m.hinst = '0; m.sc = 0; m.fc = 0;
    m.issued = '0; m.primed = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m0, input bit sync, input int cmax,
                                    input logic [31:0] pcif, input logic [31:0] word,
                                    input bit st, input bit fl);
    mdl_t m = m0;
    logic [31:0] ppc = sync ? m0.issued : pcif;
    bit          pok = sync ? m0.primed : 1'b1;
    if (fl) begin
      m.inst = RV_NOP; m.vld = 1'b0; m.held = 1'b0;
      if (m.fc < cmax) m.fc = m.fc + 1;
    end else if (st) begin
      if (!m0.held) begin m.held = 1'b1; m.hinst = word; end
      if (m.sc < cmax) m.sc = m.sc + 1;
    end else begin
      m.pc   = ppc;
      m.pc4  = ppc + 32'd4;
      m.inst = !pok ? RV_NOP : (m0.held ? m0.hinst : word);
      m.vld  = pok;
      m.held = 1'b0;
    end
    if (!st) m.issued = pcif;
    m.primed = !fl;
    return m;
  endfunction

  vec_t tbl[14];
  mdl_t ms, mc;

  initial begin
    tbl[0]  = mk(32'h0,  0,0,0, 32'h0,  32'h4,  RV_NOP,               0, 0, 0);
    tbl[1]  = mk(32'h4,  0,0,0, 32'h0,  32'h4,  rom_word(32'h0),      1, 0, 0);
    tbl[2]  = mk(32'h8,  0,0,0, 32'h4,  32'h8,  rom_word(32'h4),      1, 0, 0);
    tbl[3]  = mk(32'hC,  1,0,0, 32'h4,  32'h8,  rom_word(32'h4),      1, 1, 0);
    tbl[4]  = mk(32'hC,  1,0,1, 32'h4,  32'h8,  rom_word(32'h4),      1, 2, 0);
    tbl[5]  = mk(32'hC,  1,0,1, 32'h4,  32'h8,  rom_word(32'h4),      1, 3, 0);
    tbl[6]  = mk(32'hC,  0,0,1, 32'h8,  32'hC,  rom_word(32'h8),      1, 3, 0);
    tbl[7]  = mk(32'h10, 0,1,0, 32'h8,  32'hC,  RV_NOP,               0, 3, 1);
    tbl[8]  = mk(32'h40, 0,0,0, 32'h10, 32'h14, RV_NOP,               0, 3, 1);
    tbl[9]  = mk(32'h44, 0,0,0, 32'h40, 32'h44, rom_word(32'h40),     1, 3, 1);
    tbl[10] = mk(32'h48, 1,1,0, 32'h40, 32'h44, RV_NOP,               0, 3, 2);
    tbl[11] = mk(32'hFFFF_FFFC, 0,0,0, 32'h44, 32'h48, RV_NOP,        0, 3, 2);
    tbl[12] = mk(32'h0,  0,0,0, 32'hFFFF_FFFC, 32'h0, rom_word(32'hFFFF_FFFC), 1, 3, 2);
    tbl[13] = mk(32'h4,  0,0,0, 32'h0,  32'h4,  rom_word(32'h0),      1, 3, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",   s_pc,   32'h0);
    chk("rst_pc4",  s_pc4,  32'h4);
    chk("rst_inst", s_inst, RV_NOP);
    chk("rst_vld",  32'(s_vld), 32'h0);
    chk("rst_scnt", 32'(s_scnt), 32'h0);
    chk("rst_fcnt", 32'(s_fcnt), 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      pc_IF = tbl[i].pc; stall_ID = tbl[i].st; flush_ID = tbl[i].fl; garb = tbl[i].gb;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pc", i),   s_pc,   tbl[i].epc);
      chk($sformatf("vec%0d_pc4", i),  s_pc4,  tbl[i].epc4);
      chk($sformatf("vec%0d_inst", i), s_inst, tbl[i].einst);
      chk($sformatf("vec%0d_vld", i),  32'(s_vld),  32'(tbl[i].evld));
      chk($sformatf("vec%0d_scnt", i), 32'(s_scnt), 32'(tbl[i].esc));
      chk($sformatf("vec%0d_fcnt", i), 32'(s_fcnt), 32'(tbl[i].efc));
    end

    // Random traffic on both ROM flavours against the model.
    stall_ID = 1'b0; flush_ID = 1'b0; garb = 1'b0; use_rnd = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ms = mdl_reset();
    mc = mdl_reset();
    for (int n = 0; n < 400; n++) begin
      pc_IF    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} >> 2 << 2;
      rnd_inst = $urandom();
      stall_ID = ($urandom_range(0, 9) < 3);
      flush_ID = ($urandom_range(0, 19) < 3);
      ms = mdl_step(ms, 1'b1, 65535, pc_IF, rnd_inst, stall_ID, flush_ID);
      mc = mdl_step(mc, 1'b0, 15,    pc_IF, rnd_inst, stall_ID, flush_ID);
      @(posedge clk); #1;
      chk("rnd_s_pc",   s_pc,   ms.pc);
      chk("rnd_s_pc4",  s_pc4,  ms.pc4);
      chk("rnd_s_inst", s_inst, ms.inst);
      chk("rnd_s_vld",  32'(s_vld),  32'(ms.vld));
      chk("rnd_s_scnt", 32'(s_scnt), 32'(ms.sc));
      chk("rnd_s_fcnt", 32'(s_fcnt), 32'(ms.fc));
      chk("rnd_c_pc",   c_pc,   mc.pc);
      chk("rnd_c_pc4",  c_pc4,  mc.pc4);
      chk("rnd_c_inst", c_inst, mc.inst);
      chk("rnd_c_vld",  32'(c_vld),  32'(mc.vld));
      chk("rnd_c_scnt", 32'(c_scnt), 32'(mc.sc));
      chk("rnd_c_fcnt", 32'(c_fcnt), 32'(mc.fc));
    end

    // Saturation of the narrow counter, then reset asserted mid-cycle.
    stall_ID = 1'b0; flush_ID = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stall_ID = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_c_scnt", 32'(c_scnt), 32'd15);
    chk("sat_s_scnt", 32'(s_scnt), 32'd20);
    chk("sat_c_vld",  32'(c_vld),  32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_c_vld",  32'(c_vld),  32'd0);
    chk("arst_c_scnt", 32'(c_scnt), 32'd0);
    chk("arst_s_scnt", 32'(s_scnt), 32'd0);
    chk("arst_s_fcnt", 32'(s_fcnt), 32'd0);
    chk("arst_c_inst", c_inst, RV_NOP);
    chk("arst_c_pc4",  c_pc4,  32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
